// File: rtl/dsp_sop2_dot_ctrl_if.sv
// Handshake and slice-side bundle for the SOP2 dot-product sequencer.
// master = job/operand/result environment, slave = the sequencer.
interface dsp_sop2_dot_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [36:0]      cmd_bias;

    logic             op_valid;
    logic             op_ready;
    logic [17:0]      op_ax;
    logic [17:0]      op_bx;
    logic [18:0]      op_ay;
    logic [18:0]      op_by;

    logic [10:0]      dsp_mode_sigs;
    logic [17:0]      dsp_ax;
    logic [17:0]      dsp_bx;
    logic [18:0]      dsp_ay;
    logic [18:0]      dsp_by;
    logic [36:0]      dsp_chainin;
    logic [36:0]      dsp_resulta;

    logic             res_valid;
    logic             res_ready;
    logic [36:0]      res_data;
    logic             busy;

    modport master (
        output cmd_valid, cmd_len, cmd_bias,
        output op_valid, op_ax, op_bx, op_ay, op_by,
        output dsp_resulta, res_ready,
        input  cmd_ready, op_ready,
        input  dsp_mode_sigs, dsp_ax, dsp_bx, dsp_ay, dsp_by,
        input  dsp_chainin, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_bias,
        input  op_valid, op_ax, op_bx, op_ay, op_by,
        input  dsp_resulta, res_ready,
        output cmd_ready, op_ready,
        output dsp_mode_sigs, dsp_ax, dsp_bx, dsp_ay, dsp_by,
        output dsp_chainin, res_valid, res_data, busy
    );
endinterface

// File: rtl/dsp_sop2_dot_ctrl.sv
// Streams operand pairs into one SOP2 slice and closes the
// accumulation loop through chainin; returns the 37-bit sum.
module dsp_sop2_dot_ctrl #(
    parameter int          LEN_W     = 8,
    parameter logic [10:0] MODE_SIGS = 11'd0
) (
    input logic clk,
    input logic reset,
    dsp_sop2_dot_ctrl_if.slave io
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic [36:0]      bias_q;
    logic             first_q;
    logic             sel_bias_q;
    logic             drain_cnt;
    logic             cmd_ready_q;
    logic             op_ready_q;
    logic             res_valid_q;
    logic             busy_q;
    logic [36:0]      res_data_q;
    logic             beat;

    assign beat = io.op_valid & op_ready_q;

    // Bubbles feed zeros so the slice just re-adds chainin.
    assign io.dsp_ax = beat ? io.op_ax : '0;
    assign io.dsp_bx = beat ? io.op_bx : '0;
    assign io.dsp_ay = beat ? io.op_ay : '0;
    assign io.dsp_by = beat ? io.op_by : '0;

    assign io.dsp_chainin = sel_bias_q ? bias_q : io.dsp_resulta;
    assign io.dsp_mode_sigs = MODE_SIGS;

    assign io.cmd_ready = cmd_ready_q;
    assign io.op_ready  = op_ready_q;
    assign io.res_valid = res_valid_q;
    assign io.res_data  = res_data_q;
    assign io.busy      = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rem         <= '0;
            bias_q      <= '0;
            first_q     <= 1'b0;
            sel_bias_q  <= 1'b0;
            drain_cnt   <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_data_q  <= '0;
        end else begin
            sel_bias_q <= first_q & beat;
            unique case (state)
                IDLE: begin
                    if (io.cmd_valid) begin
                        bias_q      <= io.cmd_bias;
                        rem         <= io.cmd_len;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (io.cmd_len == '0) begin
                            state       <= HOLD;
                            res_data_q  <= io.cmd_bias;
                            res_valid_q <= 1'b1;
                        end else begin
                            state      <= STREAM;
                            first_q    <= 1'b1;
                            op_ready_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (beat) begin
                        rem     <= rem - LEN_W'(1);
                        first_q <= 1'b0;
                        if (rem == LEN_W'(1)) begin
                            state      <= DRAIN;
                            op_ready_q <= 1'b0;
                            drain_cnt  <= 1'b0;
                        end
                    end
                end
                // Two cycles for the last beat to reach resulta.
                DRAIN: begin
                    if (drain_cnt) begin
                        res_data_q  <= io.dsp_resulta;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                HOLD: begin
                    if (io.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_sop2_dot_ctrl.sv
// Bench for dsp_sop2_dot_ctrl: slice model, job-level scoreboard
// and directed jobs with hand-computed sums and latencies.
module tb_dsp_sop2_dot_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dsp_sop2_dot_ctrl_if #(.LEN_W(8)) io ();

    dsp_sop2_dot_ctrl #(
        .LEN_W(8),
        .MODE_SIGS(11'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slice: products registered, then added to next-cycle chainin.
    logic [36:0] s_p;
    always @(posedge clk) begin
        s_p <= 37'(io.dsp_ax) * 37'(io.dsp_ay)
             + 37'(io.dsp_bx) * 37'(io.dsp_by);
        io.dsp_resulta <= s_p + io.dsp_chainin;
    end

    task automatic chk(input string nm,
                       input logic [36:0] act,
                       input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Job-level model: sum of products, fixed pipeline delay.
    bit          m_cmd_ready;
    bit          m_op_ready;
    bit          m_res_valid;
    bit          m_busy;
    logic [36:0] m_res_data;
    logic [36:0] m_acc;
    int          m_beats;
    int          m_drain;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cmd_ready = 1;
            m_op_ready  = 0;
            m_res_valid = 0;
            m_busy      = 0;
            m_res_data  = '0;
            m_acc       = '0;
            m_beats     = 0;
            m_drain     = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) begin
                m_res_valid = 1;
                m_res_data  = m_acc;
            end
        end else if (m_res_valid) begin
            if (io.res_ready) begin
                m_res_valid = 0;
                m_cmd_ready = 1;
                m_busy      = 0;
            end
        end else if (m_cmd_ready) begin
            if (io.cmd_valid) begin
                m_cmd_ready = 0;
                m_busy      = 1;
                m_acc       = io.cmd_bias;
                m_beats     = int'(io.cmd_len);
                if (m_beats == 0) begin
                    m_res_valid = 1;
                    m_res_data  = io.cmd_bias;
                end else begin
                    m_op_ready = 1;
                end
            end
        end else if (m_op_ready && io.op_valid) begin
            m_acc = m_acc
                  + 37'(io.op_ax) * 37'(io.op_ay)
                  + 37'(io.op_bx) * 37'(io.op_by);
            m_beats--;
            if (m_beats == 0) begin
                m_op_ready = 0;
                m_drain    = 2;
            end
        end
    end

    always @(negedge clk) begin
        bit tk;
        tk = io.op_valid && m_op_ready;
        chk("cmd_ready", io.cmd_ready, m_cmd_ready);
        chk("op_ready", io.op_ready, m_op_ready);
        chk("res_valid", io.res_valid, m_res_valid);
        chk("busy", io.busy, m_busy);
        chk("res_data", io.res_data, m_res_data);
        chk("mode", io.dsp_mode_sigs, 37'd0);
        chk("dsp_ax", io.dsp_ax, tk ? 37'(io.op_ax) : 37'd0);
        chk("dsp_ay", io.dsp_ay, tk ? 37'(io.op_ay) : 37'd0);
        chk("dsp_bx", io.dsp_bx, tk ? 37'(io.op_bx) : 37'd0);
        chk("dsp_by", io.dsp_by, tk ? 37'(io.op_by) : 37'd0);
    end

    logic [17:0] b_ax[8];
    logic [18:0] b_ay[8];
    logic [17:0] b_bx[8];
    logic [18:0] b_by[8];

    task automatic set_beat(input int i,
                            input logic [17:0] ax,
                            input logic [18:0] ay,
                            input logic [17:0] bx,
                            input logic [18:0] by);
        b_ax[i] = ax;
        b_ay[i] = ay;
        b_bx[i] = bx;
        b_by[i] = by;
    endtask

    task automatic junk_ops();
        io.op_ax = 18'h2aaaa;
        io.op_ay = 19'h55555;
        io.op_bx = 18'h13579;
        io.op_by = 19'h2468a;
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic run_job(input int len,
                           input logic [36:0] bias,
                           input bit stall,
                           input bit early,
                           input int hold,
                           input logic [36:0] exp_data,
                           input int exp_lat);
        int c0;
        bit seen;
        c0 = cyc;
        io.cmd_valid = 1'b1;
        io.cmd_len   = 8'(len);
        io.cmd_bias  = bias;
        io.res_ready = early;
        if (len == 0) begin
            io.op_valid = 1'b1;
            junk_ops();
        end
        @(posedge clk); #1;
        io.cmd_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (stall && i > 0) begin
                io.op_valid = 1'b0;
                junk_ops();
                @(posedge clk); #1;
            end
            io.op_valid = 1'b1;
            io.op_ax = b_ax[i];
            io.op_ay = b_ay[i];
            io.op_bx = b_bx[i];
            io.op_by = b_by[i];
            @(posedge clk); #1;
        end
        io.op_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (io.res_valid) seen = 1;
        end
        chk("res_seen", 37'(seen), 37'd1);
        if (seen) begin
            chk("job_data", io.res_data, exp_data);
            chk("job_lat", 37'(cyc - c0), 37'(exp_lat));
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("hold_valid", io.res_valid, 37'd1);
                chk("hold_data", io.res_data, exp_data);
                chk("hold_cmd_rdy", io.cmd_ready, 37'd0);
            end
            io.res_ready = 1'b1;
            @(posedge clk); #1;
            io.res_ready = 1'b0;
            chk("back_idle", io.cmd_ready, 37'd1);
            chk("idle_busy", io.busy, 37'd0);
        end
    endtask

    initial begin
        io.cmd_valid = 1'b0;
        io.cmd_len   = '0;
        io.cmd_bias  = '0;
        io.op_valid  = 1'b0;
        io.op_ax     = '0;
        io.op_ay     = '0;
        io.op_bx     = '0;
        io.op_by     = '0;
        io.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", io.cmd_ready, 37'd1);
        chk("rst_res_valid", io.res_valid, 37'd0);
        chk("rst_res_data", io.res_data, 37'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        set_beat(0, 18'd2, 19'd3, 18'd4, 19'd5);
        run_job(1, 37'd5, 0, 0, 0, 37'd31, 4);

        for (int k = 1; k <= 4; k++)
            set_beat(k - 1, 18'(k), 19'(k), 18'(k), 19'(k));
        run_job(4, 37'd0, 0, 0, 0, 37'd60, 7);
        run_job(4, 37'd0, 1, 0, 0, 37'd60, 10);

        run_job(0, 37'h1_2345_6789, 0, 1, 0, 37'h1_2345_6789, 1);

        set_beat(0, 18'd1, 19'd1, 18'd0, 19'd0);
        run_job(1, 37'h1f_ffff_ffff, 0, 0, 5, 37'd0, 4);

        set_beat(0, 18'h3ffff, 19'h7ffff, 18'd0, 19'd0);
        set_beat(1, 18'h3ffff, 19'h7ffff, 18'd0, 19'd0);
        run_job(2, 37'd0, 0, 0, 0, 37'h1f_ffe8_0002, 5);

        // Abort an L=4 job after its second beat.
        io.cmd_valid = 1'b1;
        io.cmd_len   = 8'd4;
        io.cmd_bias  = 37'd0;
        @(posedge clk); #1;
        io.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            io.op_valid = 1'b1;
            io.op_ax = 18'(i + 3);
            io.op_ay = 19'(i + 3);
            io.op_bx = 18'(i + 3);
            io.op_by = 19'(i + 3);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("abort_busy", io.busy, 37'd0);
        chk("abort_op_ready", io.op_ready, 37'd0);
        chk("abort_cmd_ready", io.cmd_ready, 37'd1);
        chk("abort_res_valid", io.res_valid, 37'd0);
        chk("abort_res_data", io.res_data, 37'd0);
        chk("abort_dsp_ax", io.dsp_ax, 37'd0);
        chk("abort_dsp_by", io.dsp_by, 37'd0);
        @(posedge clk); #1;
        io.op_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        set_beat(0, 18'd1, 19'd1, 18'd0, 19'd0);
        run_job(1, 37'd0, 0, 0, 0, 37'd1, 4);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_sop2_dot_ctrl.md
# dsp_sop2_dot_ctrl

Sequencer that drives one `int_sop_2_dspchain` slice as a streaming dot-product engine. It accepts a job command (length and bias), then streams operand pairs into the slice at one pair per cycle. It closes the accumulation loop by steering the slice's `resulta` back into `chainin`, and returns the final 37-bit sum over a valid/ready result port. It sits between the operand buffers of a tile and its SOP2 DSP slice, with the slice instantiated next to it.

## Interface
- `LEN_W`, 8: width of the job length field (max job = 2^LEN_W-1 beats).
- `MODE_SIGS`, 11'd0: constant driven on `dsp_mode_sigs`.

- `clk`  in  1  clock; also clocks the DSP slice.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  job command valid.
- `cmd_ready`  out  1  controller can accept a job.
- `cmd_len`  in  LEN_W  number of operand beats in the job.
- `cmd_bias`  in  37  initial accumulator value.
- `op_valid`  in  1  operand beat valid.
- `op_ready`  out  1  controller accepts an operand beat.
- `op_ax`, `op_bx`  in  18  first multiplicands.
- `op_ay`, `op_by`  in  19  second multiplicands.
- `dsp_mode_sigs`  out  11  equals `MODE_SIGS`.
- `dsp_ax`, `dsp_bx`  out  18  operands to the slice.
- `dsp_ay`, `dsp_by`  out  19  operands to the slice.
- `dsp_chainin`  out  37  chain input to the slice.
- `dsp_resulta`  in  37  registered result from the slice.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  37  final dot-product sum.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Slice model (fixed):
  - Operands presented in cycle t are registered at the end of t.
  - The sum `ax*ay + bx*by + chainin` uses the `chainin` value presented in cycle t+1.
  - The sum appears on `dsp_resulta` in cycle t+2.
- FSM states: IDLE, STREAM, DRAIN, HOLD.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_bias` into `bias_q` and `cmd_len` into `rem`.
    - If `cmd_len`=0, go to HOLD with `res_data`=`cmd_bias`.
    - Otherwise go to STREAM and set `first_q`=1.
  - STREAM: `op_ready`=1.
    - Each accepted beat (`op_valid`&`op_ready`) drives the `op_*` values onto `dsp_*` in that same cycle and decrements `rem`.
    - The beat accepted with `rem`=1 moves the FSM to DRAIN.
  - DRAIN: lasts exactly 2 cycles, counted by a 1-bit counter. At the end of the second cycle, `res_data` <= `dsp_resulta`, then go to HOLD.
  - HOLD: `res_valid`=1 and `res_data` stable. On `res_ready`, go to IDLE.
- Operand outputs: `dsp_ax/ay/bx/by` are driven to 0 in every cycle without an accepted beat (idle, stall bubble, DRAIN, HOLD). A bubble therefore adds 0 and the accumulator holds its value.
- Chain steering, per cycle:
  - `dsp_chainin` = `bias_q` in the cycle after the first beat of a job is accepted.
  - `dsp_chainin` = `dsp_resulta` in every other cycle.
  - `first_q` clears when the first beat is accepted; a 1-cycle delayed copy selects `bias_q`.
- Arithmetic: unsigned, modulo 2^37, matching the slice. The controller performs no arithmetic beyond the `rem` decrement.
- Only one job is in flight at a time. `cmd_ready`=0 outside IDLE; a command presented then is held by the producer, not dropped.
- Stale slice state from an earlier job or a reset is irrelevant, because the first beat's `chainin` is always `bias_q`.

## Timing
- Reset values (asynchronous):
  - State IDLE, `cmd_ready`=1.
  - `op_ready`=0, `res_valid`=0, `busy`=0.
  - `res_data`=0, `bias_q`=0, `rem`=0, `first_q`=0.
  - All `dsp_*` operands 0.
- Reset mid-job aborts the job: no result is produced, and the next job after release is correct.
- Latency, no stalls, L≥1:
  - Command accepted in cycle 0.
  - Beats accepted in cycles 1..L.
  - DRAIN in cycles L+1 and L+2.
  - `res_valid` rises in cycle L+3.
- Latency for L=0: `res_valid` rises in cycle 1.
- Each `op_valid` low cycle in STREAM adds one cycle of latency.
- Throughput: one beat per cycle in STREAM. Minimum job-to-job gap is DRAIN + HOLD (≥1) + IDLE (1).
- A `res_ready` already high when HOLD is entered completes in that first HOLD cycle; IDLE follows in the next cycle.

## Test plan
- L=1, bias=5, beat (2,3,4,5) -> `res_data`=31, `res_valid` in cycle 4.
- L=4, bias=0, beats ax=ay=bx=by=k for k=1..4, no stalls -> 2·(1+4+9+16)=60, `res_valid` in cycle 7.
- Same job with `op_valid` dropped on alternate cycles -> still 60; latency +3; `dsp_*` operands are 0 in every bubble cycle.
- L=0, bias=37'h1_2345_6789 -> `res_valid` in cycle 1 with `res_data`=bias, and no beat accepted.
- Wrap: bias=2^37-1, L=1, ax=ay=1, bx=by=0 -> `res_data`=0. `res_ready` held low 5 cycles -> `res_valid` and `res_data` stable, `cmd_ready`=0 throughout.
- Reset asserted after beat 2 of an L=4 job -> all outputs at reset values immediately. After release, a new L=1 job with (1,1,0,0) and bias=0 -> `res_data`=1.
